// File: rtl/mem_line_arbiter_if.sv
// Cache/memory line bus shared by the i-cache, d-cache and main memory around mem_line_arbiter.
// slave = arbiter view; master = environment (caches + memory) view.
interface mem_line_arbiter_if #(
    parameter int WORD_SIZE = 16
);
    logic                     i_readM;
    logic [15:0]              i_addr;
    logic [4*WORD_SIZE-1:0]   i_rdata;
    logic                     i_ready;

    logic                     d_readM;
    logic                     d_writeM;
    logic [15:0]              d_addr;
    logic [4*WORD_SIZE-1:0]   d_wdata;
    logic [4*WORD_SIZE-1:0]   d_rdata;
    logic                     d_ready;

    logic                     mem_readM;
    logic                     mem_writeM;
    logic [15:0]              mem_addr;
    logic [4*WORD_SIZE-1:0]   mem_wdata;
    logic [4*WORD_SIZE-1:0]   mem_rdata;

    modport slave (
        input  i_readM, i_addr, d_readM, d_writeM, d_addr, d_wdata, mem_rdata,
        output i_rdata, i_ready, d_rdata, d_ready,
               mem_readM, mem_writeM, mem_addr, mem_wdata
    );

    modport master (
        output i_readM, i_addr, d_readM, d_writeM, d_addr, d_wdata, mem_rdata,
        input  i_rdata, i_ready, d_rdata, d_ready,
               mem_readM, mem_writeM, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_line_arbiter.sv
// Arbitrates i-/d-cache line reads and d-cache write-backs onto one fixed-latency memory port (ARB_ROUND_ROBIN_EN: fair arbitration).
// Ready pulses LATENCY+1 cycles after the grant edge; losers simply hold their level request until served.
module mem_line_arbiter #(
    parameter int WORD_SIZE = 16,
    parameter int LATENCY   = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    mem_line_arbiter_if.slave   bus
);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count;
    logic            owner_d;
    logic            grant_d, grant_i;
    logic            d_req, prefer_d;

    assign d_req = bus.d_readM | bus.d_writeM;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner;  // 1 = d-cache was served last
    assign prefer_d = ~last_owner;

    always_ff @(posedge clk) begin
        if (!reset_n)
            last_owner <= 1'b0;
        else if (grant_d || grant_i)
            last_owner <= grant_d;
    end
`else
    assign prefer_d = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_i   = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && (!bus.i_readM || prefer_d))
                    grant_d = 1'b1;
                else if (bus.i_readM)
                    grant_i = 1'b1;
                if (d_req || bus.i_readM)
                    state_nxt = BUSY;
            end
            BUSY: begin
                if (count == LAST)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count          <= '0;
            owner_d        <= 1'b0;
            bus.mem_readM  <= 1'b0;
            bus.mem_writeM <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.i_rdata    <= '0;
            bus.d_rdata    <= '0;
            bus.i_ready    <= 1'b0;
            bus.d_ready    <= 1'b0;
        end else begin
            bus.i_ready <= 1'b0;
            bus.d_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d || grant_i) begin
                        count   <= '0;
                        owner_d <= grant_d;
                        if (grant_d) begin
                            bus.mem_addr <= bus.d_addr;
                            // A write-back beats a simultaneous d read; the read stays pending.
                            if (bus.d_writeM) begin
                                bus.mem_writeM <= 1'b1;
                                bus.mem_wdata  <= bus.d_wdata;
                            end else begin
                                bus.mem_readM  <= 1'b1;
                            end
                        end else begin
                            bus.mem_addr  <= bus.i_addr;
                            bus.mem_readM <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        bus.mem_readM  <= 1'b0;
                        bus.mem_writeM <= 1'b0;
                        if (owner_d) begin
                            bus.d_ready <= 1'b1;
                            if (bus.mem_readM)
                                bus.d_rdata <= bus.mem_rdata;
                        end else begin
                            bus.i_ready <= 1'b1;
                            bus.i_rdata <= bus.mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
